hp_vpu_lut_engine: RTL and testbench

- Parametrised, runtime-loadable nonlinear-function lookup engine for the VPU activation path; successor to the fixed combinational LUT ROM.
- Holds NUM_FUNC tables of DEPTH entries each, mapped to inferred synchronous BRAM. Tables are written through a load port.
- Serves one lookup per cycle through a 2-stage valid/ready pipeline with backpressure. Reports lookups into tables that are not loaded.

---
 rtl/hp_vpu_lut_engine.sv | 144 ++++++++++++++
 tb/tb_hp_vpu_lut_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_vpu_lut_engine.sv
// hp_vpu_lut_engine: runtime-loadable activation LUT, NUM_FUNC tables x DEPTH
// entries in one synchronous RAM, served by a 2-stage valid/ready pipeline.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   in_valid_i/in_ready_o     lookup request handshake (index_i, func_sel_i)
//   out_valid_o/out_ready_i   result handshake (result_o, err_o)
//   wr_en_i/wr_func_i/
//   wr_addr_i/wr_data_i       table write port, always accepted
//   clear_i                   pulse, clears all loaded flags
//   loaded_o                  per-table loaded flags
module hp_vpu_lut_engine #(
  parameter int NUM_FUNC = 4,
  parameter int DEPTH    = 256,
  parameter int DATA_W   = 16,
  parameter int FUNC_W   = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [FUNC_W-1:0] func_sel_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              err_o,
  input  logic              wr_en_i,
  input  logic [FUNC_W-1:0] wr_func_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clear_i,
  output logic [NUM_FUNC-1:0] loaded_o
);

  localparam int ADDR_W = FUNC_W + IDX_W;
  localparam int WORDS  = NUM_FUNC * DEPTH;
  localparam int FN     = 2 ** FUNC_W;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(DEPTH - 1);

  // One bit per encodable func code; codes at or
  // above NUM_FUNC read as zero (not a table).
  localparam logic [FN-1:0] FUNC_OK =
    FN'({NUM_FUNC{1'b1}});

  logic [DATA_W-1:0] mem [WORDS];

  logic                s1_valid_q, s1_valid_d;
  logic                s1_err_q, s1_err_d;
  logic [DATA_W-1:0]   rd_q;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic [NUM_FUNC-1:0] loaded_q, loaded_d;

  logic              advance;
  logic              in_fire;
  logic              rd_en;
  logic              wr_ok;
  logic [FN-1:0]     loaded_ext;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign advance    = !out_valid_q || out_ready_i;
  assign in_ready_o = advance;
  assign in_fire    = in_valid_i && advance;

  // Zero-padded so out-of-range func codes
  // look like unloaded tables.
  assign loaded_ext = FN'(loaded_q);

  assign rd_en   = in_fire && FUNC_OK[func_sel_i];
  assign wr_ok   = wr_en_i && FUNC_OK[wr_func_i];
  assign rd_addr = {func_sel_i, index_i};
  assign wr_addr = {wr_func_i, wr_addr_i};

  // Table storage: no reset, read-first on a
  // same-address collision. The read happens
  // only on acceptance, so a stall issues none.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data_i;
    end
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  always_comb begin
    loaded_d = clear_i ? '0 : loaded_q;
    // Set after clear so a final-entry write
    // in the clear cycle keeps its table loaded.
    if (wr_ok && (wr_addr_i == LAST_IDX)) begin
      loaded_d[wr_func_i] = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;
    if (advance) begin
      s1_valid_d  = in_fire;
      out_valid_d = s1_valid_q;
      if (in_fire) begin
        s1_err_d = !loaded_ext[func_sel_i];
      end
      // Bubbles leave result/err untouched.
      if (s1_valid_q) begin
        result_d = s1_err_q ? '0 : rd_q;
        err_d    = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      loaded_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      loaded_q    <= loaded_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign err_o       = err_q;
  assign loaded_o    = loaded_q;

endmodule

// File: tb/tb_hp_vpu_lut_engine.sv
// tb_hp_vpu_lut_engine: directed bench for the LUT engine.
// Vector table for single lookups plus hand-written multi-cycle sequences.
module tb_hp_vpu_lut_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  index = '0;
  logic [1:0]  func_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        err;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_func = '0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        clear = 1'b0;
  logic [3:0]  loaded;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hp_vpu_lut_engine dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .index_i     (index),
    .func_sel_i  (func_sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .err_o       (err),
    .wr_en_i     (wr_en),
    .wr_func_i   (wr_func),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .clear_i     (clear),
    .loaded_o    (loaded)
  );

  typedef struct {
    logic [1:0]  func;
    logic [7:0]  idx;
    logic [15:0] data;
    logic        err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] f,
                    input logic [7:0] a,
                    input logic [15:0] d);
    wr_en = 1'b1;
    wr_func = f;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] f,
                        input logic [7:0] i,
                        input logic [15:0] d,
                        input logic e,
                        input string nm);
    in_valid = 1'b1;
    func_sel = f;
    index = i;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({nm, "_n1_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_data"}, 32'(result), 32'(d));
    check({nm, "_err"}, 32'(err), 32'(e));
    tick();
  endtask

  task automatic stream(input logic [3:0] pat,
                        input string nm);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int gaps = 0;
    bit started = 0;
    bit prev_stall = 0;
    logic [15:0] prev_res = '0;
    while (got < 256 && cyc < 3000) begin
      in_valid = (sent < 256);
      func_sel = 2'd1;
      index = 8'(sent);
      out_ready = pat[cyc % 4];
      #1;
      if (prev_stall) begin
        check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_hold_data"}, 32'(result), 32'(prev_res));
      end
      if (out_valid === 1'b1 && !out_ready) begin
        check({nm, "_stall_rdy"}, 32'(in_ready), 32'd0);
      end
      if (out_valid === 1'b1 && out_ready) begin
        check($sformatf("%s_r%0d", nm, got), 32'(result),
              32'h1000 + 32'(got));
        check($sformatf("%s_e%0d", nm, got), 32'(err), 32'd0);
        got++;
        started = 1;
      end else if (started && out_valid !== 1'b1) begin
        gaps++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_res = result;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({nm, "_count"}, 32'(got), 32'd256);
    if (pat == 4'hF) check({nm, "_gaps"}, 32'(gaps), 32'd0);
    tick();
    tick();
    check({nm, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'd1, 8'd0,   16'h1000, 1'b0};
    vecs[1] = '{2'd1, 8'd255, 16'h10FF, 1'b0};
    vecs[2] = '{2'd1, 8'd128, 16'h1080, 1'b0};
    vecs[3] = '{2'd2, 8'd0,   16'h2000, 1'b0};
    vecs[4] = '{2'd2, 8'd255, 16'h20FF, 1'b0};
    vecs[5] = '{2'd2, 8'd7,   16'hAAAA, 1'b0};
    vecs[6] = '{2'd0, 8'd5,   16'h0000, 1'b1};
    vecs[7] = '{2'd3, 8'd255, 16'h0000, 1'b1};

    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    lookup(2'd0, 8'd5, 16'h0000, 1'b1, "unloaded");

    for (int i = 0; i < 256; i++) begin
      wr(2'd1, 8'(i), 16'h1000 + 16'(i));
    end
    check("load1", 32'(loaded), 32'b0010);
    for (int i = 0; i < 256; i++) begin
      wr(2'd2, 8'(i), (i == 7) ? 16'hAAAA : 16'h2000 + 16'(i));
    end
    check("load2", 32'(loaded), 32'b0110);

    for (int i = 0; i < 8; i++) begin
      lookup(vecs[i].func, vecs[i].idx, vecs[i].data,
             vecs[i].err, $sformatf("vec%0d", i));
    end

    stream(4'hF, "stream");
    stream(4'b1001, "stall");

    // Read-during-write returns old data
    in_valid = 1'b1;
    func_sel = 2'd2;
    index = 8'd7;
    wr_en = 1'b1;
    wr_func = 2'd2;
    wr_addr = 8'd7;
    wr_data = 16'h5555;
    tick();
    in_valid = 1'b0;
    wr_en = 1'b0;
    tick();
    check("rdw_valid", 32'(out_valid), 32'd1);
    check("rdw_old", 32'(result), 32'hAAAA);
    tick();
    lookup(2'd2, 8'd7, 16'h5555, 1'b0, "rdw_new");

    // Clear with two requests in flight
    in_valid = 1'b1;
    func_sel = 2'd1;
    index = 8'd3;
    tick();
    index = 8'd4;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    index = 8'd5;
    check("clr_loaded", 32'(loaded), 32'd0);
    check("clr_a_valid", 32'(out_valid), 32'd1);
    check("clr_a_data", 32'(result), 32'h1003);
    check("clr_a_err", 32'(err), 32'd0);
    tick();
    in_valid = 1'b0;
    check("clr_b_data", 32'(result), 32'h1004);
    check("clr_b_err", 32'(err), 32'd0);
    tick();
    check("clr_c_valid", 32'(out_valid), 32'd1);
    check("clr_c_data", 32'(result), 32'd0);
    check("clr_c_err", 32'(err), 32'd1);
    tick();

    // Clear and final-entry write in the same cycle
    wr(2'd1, 8'd255, 16'h10FF);
    check("reload1", 32'(loaded), 32'b0010);
    clear = 1'b1;
    wr(2'd3, 8'd255, 16'h3FFF);
    clear = 1'b0;
    check("clr_set", 32'(loaded), 32'b1000);

    // Reset with two requests in flight
    in_valid = 1'b1;
    func_sel = 2'd3;
    index = 8'd255;
    tick();
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_loaded", 32'(loaded), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_%0d", i), 32'(out_valid), 32'd0);
    end
    wr(2'd1, 8'd255, 16'h10FF);
    lookup(2'd1, 8'd9, 16'h1009, 1'b0, "survive");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
